psum_accum_drain: RTL and testbench
===================================

Name: psum_accum_drain

Overview:
- Consumer side of the MAC column output: receives per-column psum vectors over a valid/ready handshake.
- Accumulates a programmable number of vectors (kernel positions) per lane with signed saturation.
- Presents the finished vector on a second valid/ready output port.
- Sits between the MAC array column outputs and the ofifo/SRAM write path.

Parameters:
psum_bw, 16, width of each signed psum lane (input and output)
col, 8, number of lanes (array columns) handled in parallel
len_bw, 4, width of the accumulation-length field

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
acc_len  input  len_bw  beats per group, sampled on first beat of a group
in_valid  input  1  in_psum carries a valid vector
in_ready  output  1  block can accept a vector this cycle
in_psum  input  col*psum_bw  lane i = bits [i*psum_bw +: psum_bw], signed
out_valid  output  1  out_data holds a finished group
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  col*psum_bw  accumulated vector, same lane packing
busy  output  1  high in ACCUM or DRAIN

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, count=0, acc lanes=0, out_data=0, out_valid=0, in_ready=0, busy=0.
- in_ready comes from a flop set on the first clk after reset_n rises. It equals (ready_flop && state!=DRAIN).
- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready on a rising edge.
- IDLE:
  - On an input transfer, load acc=in_psum and latch len = (acc_len==0 ? 1 : acc_len).
  - If len==1, go to DRAIN and load out_data in the same edge. Otherwise set count=1 and go to ACCUM.
- ACCUM:
  - Each input transfer performs acc_i = sat(acc_i + in_psum_i) and count++.
  - On the transfer where count+1==len, register the saturated sum into out_data, set out_valid=1, go to DRAIN.
- DRAIN: in_ready=0. Hold out_data/out_valid stable until an output transfer, then out_valid=0, count=0, state=IDLE.
- Latency: out_valid rises on the edge of the last input transfer, so it is visible the next cycle. Minimum group period is len+1 cycles.
- Arithmetic:
  - Sum is formed in psum_bw+1 bits.
  - Result clamps to SAT_MAX=2^(psum_bw-1)-1 or SAT_MIN=-2^(psum_bw-1).
  - After saturation the accumulator keeps the clamped value (no wrap).
- Boundaries:
  - acc_len changes mid-group are ignored.
  - in_valid in DRAIN is not accepted; the producer must hold its data.
  - out_ready asserted with out_valid=0 has no effect.
  - An input bubble in ACCUM leaves count and acc unchanged.
  - reset_n low mid-group discards the group. No partial output is produced.

Optional Feature:
- Macro: PSUM_RELU_EN
- Defined: out_data lanes with negative accumulated value are output as 0. The internal accumulator and saturation are unchanged; ReLU is applied only when out_data is loaded.
- Undefined: out_data is the signed saturated accumulation exactly.

Decomposition:
- Shared package psum_pkg:
  - state encoding IDLE/ACCUM/DRAIN
  - SAT_MAX/SAT_MIN derived from psum_bw
  - lane slice helper constant
- One natural sub-module: psum_sat_add, one signed saturating adder per lane, instantiated col times via generate.

Test Plan:
- Reset: hold reset_n low with in_valid=1 -> in_ready=0, out_valid=0, out_data=0. in_ready=1 on the second cycle after release.
- acc_len=3, col=2: three beats with lanes {5,-2}, {7,-3}, {1,4} -> one output {13,-1}, out_valid visible the cycle after beat 3.
- Saturation: acc_len=2, lane0 beats 30000 then 10000 -> out lane0=32767. Beats -30000 then -10000 -> -32768.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, next in_psum not consumed. Releasing out_ready produces one transfer, then return to IDLE.
- acc_len=0 and acc_len=1: single beat {9,-9} -> output {9,-9} (PSUM_RELU_EN defined: {9,0}).
- Reset mid-group: reset_n low after 2 of 4 beats -> no out_valid. The next full group of 4 beats of 1 outputs 4 per lane.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared definitions for the psum accumulate/drain slice: FSM states,
// saturation bounds as a function of lane width, and lane slice offsets.
package psum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } psum_state_t;

  function automatic longint sat_max(input int bw);
    return (longint'(1) <<< (bw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int bw);
    return -(longint'(1) <<< (bw - 1));
  endfunction

  function automatic int lane_lo(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// One signed saturating adder lane: the sum is formed one bit wider and
// clamped to the signed range of BW bits.
module psum_sat_add
  import psum_pkg::*;
#(
  parameter int BW = 16
) (
  input  logic signed [BW-1:0] i_a,
  input  logic signed [BW-1:0] i_b,
  output logic signed [BW-1:0] o_y
);

  localparam logic signed [BW-1:0] L_MAX = BW'(sat_max(BW));
  localparam logic signed [BW-1:0] L_MIN = BW'(sat_min(BW));

  logic signed [BW:0] w_sum;

  assign w_sum = {i_a[BW-1], i_a} + {i_b[BW-1], i_b};

  // The two top bits of the widened sum disagree exactly on overflow.
  always_comb begin
    o_y = w_sum[BW-1:0];
    if (w_sum[BW] != w_sum[BW-1]) begin
      o_y = w_sum[BW] ? L_MIN : L_MAX;
    end
  end

endmodule

// File: rtl/psum_accum_drain.sv
// Accumulates acc_len psum vectors per group with per-lane saturation and
// presents the result on a valid/ready output. Define PSUM_RELU_EN to clamp
// negative output lanes to zero.
module psum_accum_drain
  import psum_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int len_bw  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [len_bw-1:0]      acc_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [col*psum_bw-1:0] in_psum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   busy
);

  psum_state_t             r_state;
  logic                    r_rdy;
  logic [len_bw-1:0]       r_count;
  logic [len_bw-1:0]       r_len;
  logic [col*psum_bw-1:0]  r_acc;
  logic [col*psum_bw-1:0]  r_out_data;
  logic                    r_out_valid;

  logic [col*psum_bw-1:0]  w_sum;
  logic [col*psum_bw-1:0]  w_src;
  logic [col*psum_bw-1:0]  w_load;
  logic [len_bw-1:0]       w_len_in;
  logic                    w_in_xfer;
  logic                    w_out_xfer;

  assign in_ready   = r_rdy && (r_state != DRAIN);
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = (r_state != IDLE);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_len_in   = (acc_len == '0) ? len_bw'(1) : acc_len;
  // A single-beat group drains the raw input; longer groups drain the sum.
  assign w_src      = (r_state == IDLE) ? in_psum : w_sum;

  for (genvar g = 0; g < col; g++) begin : g_lane
    localparam int LO = lane_lo(g, psum_bw);

    psum_sat_add #(.BW(psum_bw)) u_add (
      .i_a (r_acc[LO +: psum_bw]),
      .i_b (in_psum[LO +: psum_bw]),
      .o_y (w_sum[LO +: psum_bw])
    );

`ifdef PSUM_RELU_EN
    assign w_load[LO +: psum_bw] = w_src[LO + psum_bw - 1] ? '0 : w_src[LO +: psum_bw];
`else
    assign w_load[LO +: psum_bw] = w_src[LO +: psum_bw];
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_rdy       <= 1'b0;
      r_count     <= '0;
      r_len       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_in_xfer) begin
            r_acc <= in_psum;
            r_len <= w_len_in;
            if (w_len_in == len_bw'(1)) begin
              r_out_data  <= w_load;
              r_out_valid <= 1'b1;
              r_state     <= DRAIN;
            end else begin
              r_count <= len_bw'(1);
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_in_xfer) begin
            r_acc   <= w_sum;
            r_count <= r_count + len_bw'(1);
            if (r_count + len_bw'(1) == r_len) begin
              r_out_data  <= w_load;
              r_out_valid <= 1'b1;
              r_state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_count     <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum_drain.sv
// Bench for psum_accum_drain (col=2, psum_bw=16): directed vector table,
// multi-cycle corner sequences, then randomized traffic against a group model.
module tb_psum_accum_drain;

  localparam int BW  = 16;
  localparam int COL = 2;
  localparam int LBW = 4;

  logic                clk;
  logic                reset_n;
  logic [LBW-1:0]      acc_len;
  logic                in_valid;
  logic                in_ready;
  logic [COL*BW-1:0]   in_psum;
  logic                out_valid;
  logic                out_ready;
  logic [COL*BW-1:0]   out_data;
  logic                busy;

  int errors = 0;
  int checks = 0;

  psum_accum_drain #(.psum_bw(BW), .col(COL), .len_bw(LBW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .acc_len   (acc_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_psum   (in_psum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int name_id;
    int len;
    int n;
    int l0[4];
    int l1[4];
    int e0;
    int e1;
  } vec_t;

  function automatic logic [COL*BW-1:0] pack2(input int a, input int b);
    logic [31:0] ua;
    logic [31:0] ub;
    ua = a;
    ub = b;
    return {ub[15:0], ua[15:0]};
  endfunction

  function automatic int lane(input logic [COL*BW-1:0] v, input int i);
    logic [15:0] s;
    s = v[i*BW +: BW];
    return int'($signed(s));
  endfunction

  function automatic int sat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int relu(input int x);
`ifdef PSUM_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int v0, input int v1, input int len);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_psum  = pack2(v0, v1);
    acc_len  = LBW'(len);
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic drain_check(input string name, input int e0, input int e1);
    @(negedge clk);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_lane0"}, lane(out_data, 0), relu(e0));
    chk({name, "_lane1"}, lane(out_data, 1), relu(e1));
    chk({name, "_in_ready"}, int'(in_ready), 0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk({name, "_cleared"}, int'(out_valid), 0);
    tick();
  endtask

  // Group-level reference: a group opens on its first accepted beat, closes
  // after its latched length, and each closed group is one expected output.
  int m_len, m_cnt;
  int m_acc[COL];
  int q0[$];
  int q1[$];

  function automatic int rnd_lane();
    logic [15:0] r;
    if ($urandom_range(0, 3) == 0) begin
      r = 16'($urandom);
      return int'($signed(r));
    end
    return int'($urandom_range(0, 400)) - 200;
  endfunction

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 3, 3, '{5, 7, 1, 0}, '{-2, -3, 4, 0}, 13, -1};
    tbl[1] = '{1, 2, 2, '{30000, 10000, 0, 0}, '{0, 0, 0, 0}, 32767, 0};
    tbl[2] = '{2, 2, 2, '{-30000, -10000, 0, 0}, '{0, 0, 0, 0}, -32768, 0};
    tbl[3] = '{3, 0, 1, '{9, 0, 0, 0}, '{-9, 0, 0, 0}, 9, -9};
    tbl[4] = '{4, 1, 1, '{9, 0, 0, 0}, '{-9, 0, 0, 0}, 9, -9};
    tbl[5] = '{5, 4, 4, '{32767, 1, -5, 0}, '{-32768, -1, 5, 0}, 32762, -32763};

    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_psum   = pack2(1234, -77);
    acc_len   = 4'd3;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_busy", int'(busy), 0);
    in_valid = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
    chk("release_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    chk("release_in_ready_high", int'(in_ready), 1);
    tick();

    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < tbl[i].n; b++) begin
        send_beat(tbl[i].l0[b], tbl[i].l1[b],
                  (b == 0) ? tbl[i].len : int'($urandom_range(0, 15)));
      end
      drain_check($sformatf("vec%0d", tbl[i].name_id), tbl[i].e0, tbl[i].e1);
    end

    send_beat(100, -100, 2);
    send_beat(23, 0, 9);
    in_valid = 1'b1;
    in_psum  = pack2(7, 8);
    acc_len  = 4'd1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_lane0", lane(out_data, 0), relu(123));
      chk("bp_lane1", lane(out_data, 1), relu(-100));
      chk("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_one_transfer", int'(out_valid), 0);
    chk("bp_idle_ready", int'(in_ready), 1);
    chk("bp_idle_busy", int'(busy), 0);
    tick();
    in_valid = 1'b0;
    drain_check("bp_next", 7, 8);

    send_beat(1, 1, 4);
    send_beat(1, 1, 4);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    for (int b = 0; b < 3; b++) send_beat(1, 1, (b == 0) ? 4 : 2);
    @(negedge clk);
    chk("midrst_no_early_out", int'(out_valid), 0);
    tick();
    send_beat(1, 1, 1);
    drain_check("midrst_group", 4, 4);

    m_len = 0;
    m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 65);
      in_psum   = pack2(rnd_lane(), rnd_lane());
      acc_len   = ($urandom_range(0, 7) == 0) ? LBW'($urandom_range(0, 15))
                                              : LBW'($urandom_range(0, 4));
      out_ready = ($urandom_range(0, 99) < 50);
      @(negedge clk);
      chk("rnd_out_valid", int'(out_valid), int'(q0.size() > 0));
      chk("rnd_in_ready", int'(in_ready), int'(q0.size() == 0));
      chk("rnd_busy", int'(busy), int'(q0.size() > 0 || m_cnt > 0));
      if (out_valid && out_ready) begin
        if (q0.size() == 0) begin
          chk("rnd_unexpected_output", 1, 0);
        end else begin
          chk("rnd_lane0", lane(out_data, 0), q0.pop_front());
          chk("rnd_lane1", lane(out_data, 1), q1.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (m_cnt == 0) begin
          m_len = (acc_len == 0) ? 1 : int'(acc_len);
          for (int l = 0; l < COL; l++) m_acc[l] = lane(in_psum, l);
        end else begin
          for (int l = 0; l < COL; l++) m_acc[l] = sat(m_acc[l] + lane(in_psum, l));
        end
        m_cnt++;
        if (m_cnt == m_len) begin
          q0.push_back(relu(m_acc[0]));
          q1.push_back(relu(m_acc[1]));
          m_cnt = 0;
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
